seq_multiplier: RTL and testbench
=================================

// Module: seq_multiplier
// PURPOSE
//   Unsigned shift-and-add multiplier built from Adder/shift_register-style datapath plus control FSM.
//   Accepts operand pairs via valid/ready handshake.
//   Produces a 2*WIDTH-bit product after a fixed WIDTH-cycle iteration.
//   Sits upstream of result Register/MagComp consumers; holds the result until the consumer takes it.
// PARAMETERS
//   WIDTH  8  operand width in bits (>=2); product is 2*WIDTH bits
// PORTS
//   clock      in   1          single clock; all state updates on posedge clock
//   reset_L    in   1          synchronous, active-low reset
//   in_valid   in   1          operand pair A/B valid
//   in_ready   out  1          block can accept operands
//   A          in   WIDTH      multiplicand, unsigned
//   B          in   WIDTH      multiplier, unsigned
//   out_valid  out  1          P holds a completed product
//   out_ready  in   1          consumer accepts P
//   P          out  2*WIDTH    product register
// BEHAVIOUR
//   Reset: clock is the only clock; reset_L is synchronous, active-low, sampled at posedge clock.
//     reset_L=0 at an edge -> state IDLE, in_ready=1, out_valid=0, P=0, count=0,
//     internal mcand/mplier/acc = 0.
//     Reset overrides all other inputs, and aborts CALC or DONE mid-operation; no partial result is emitted.
//   State IDLE (in_ready=1, out_valid=0):
//     Edge with in_valid=1 -> mcand={WIDTH'0,A}, mplier=B, acc=0, count=0 -> CALC.
//     Otherwise stay in IDLE.
//   State CALC (in_ready=0, out_valid=0), each edge:
//     if mplier[0]: acc <= acc + mcand, 2*WIDTH-bit add, carry-out discarded (cannot overflow).
//     mcand <= mcand<<1; mplier <= mplier>>1; count <= count+1.
//     When count==WIDTH-1 at the edge: P <= final acc value (including this cycle's add) -> DONE.
//     Always exactly WIDTH cycles; no early exit for zero operands.
//   State DONE (in_ready=0, out_valid=1):
//     P and out_valid held stable while out_ready=0 (arbitrary backpressure).
//     Edge with out_ready=1 -> IDLE; out_valid=0, in_ready=1 from the next cycle.
//     No same-cycle turnaround: a new operand cannot be accepted in the cycle P is taken.
//     P keeps its last value after the handshake until overwritten by the next result.
//   Latency: accept edge at cycle k -> out_valid=1 after edge k+WIDTH.
//     Minimum issue interval is WIDTH+2 cycles.
//   in_valid while in_ready=0 is ignored; A/B are sampled only on the accept edge,
//     so later changes do not affect the result.
//   count width: $clog2(WIDTH).
//   All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
// TESTING (WIDTH=8)
//   1. reset_L=0 for 2 edges with in_valid=1, out_ready=1
//      -> in_ready=1, out_valid=0, P=0; no operation started.
//   2. A=13, B=11 accepted, out_ready=1
//      -> out_valid rises exactly 8 cycles after accept, P=143 (0x008F),
//      -> in_ready=1 one cycle after the result handshake.
//   3. A=255, B=255 -> P=65025 (0xFE01); A=0, B=200 -> P=0, still 8-cycle latency.
//   4. Result ready, out_ready=0 for 5 cycles, in_valid=1 with A=3, B=4 toggling
//      -> P and out_valid stable, in_ready=0, no new capture;
//      -> after out_ready=1, next accept yields P=12.
//   5. Change A/B every cycle during CALC after accepting A=7, B=9 -> P=63.
//   6. reset_L=0 at the 3rd CALC edge
//      -> IDLE next cycle, out_valid never asserts, P=0;
//      -> subsequent A=5, B=6 -> P=30.

Source files
------------

// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Brief    : Unsigned shift-and-add multiplier, WIDTH-cycle iteration,
//            valid/ready on both operand and product sides.
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_L,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P
);

    localparam int          c_CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    localparam logic [1:0]  c_IDLE = 2'd0;
    localparam logic [1:0]  c_CALC = 2'd1;
    localparam logic [1:0]  c_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [c_CW-1:0]      r_count;
    logic [2*WIDTH-1:0]   r_p;
    logic [2*WIDTH-1:0]   w_acc_next;
    logic                 w_last;

    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_last     = (r_count == c_LAST);
    assign P          = r_p;

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: if (in_valid)  w_state_next = c_CALC;
            c_CALC: if (w_last)    w_state_next = c_DONE;
            c_DONE: if (out_ready) w_state_next = c_IDLE;
            default:               w_state_next = c_IDLE;
        endcase
    end

    // Handshake flags decode from state only, keeping inputs off output paths.
    always_comb begin
        in_ready  = (r_state == c_IDLE);
        out_valid = (r_state == c_DONE);
    end

    always_ff @(posedge clock) begin
        if (!reset_L) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
            r_p      <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= {{WIDTH{1'b0}}, A};
                        r_mplier <= B;
                        r_acc    <= '0;
                        r_count  <= '0;
                    end
                end
                c_CALC: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + c_CW'(1);
                    if (w_last) begin
                        r_p <= w_acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier
// Brief    : Directed plus randomized bench for seq_multiplier (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    localparam int W = 8;

    logic            clock = 1'b0;
    logic            reset_L;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    A;
    logic [W-1:0]    B;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  P;

    int checks = 0;
    int errors = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset_L   (reset_L),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: product is plain integer multiplication, ready WIDTH edges after accept.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input int stall);
        logic [2*W-1:0] exp_p;
        exp_p = 16'({8'd0, a} * {8'd0, b});
        A = a; B = b; in_valid = 1'b1; out_ready = 1'b0;
        check("idle_ready", 32'(in_ready), 32'd1);
        step();
        check("accept_busy", 32'(in_ready), 32'd0);
        for (int i = 1; i <= W; i++) begin
            A = W'($urandom); B = W'($urandom); in_valid = 1'($urandom);
            step();
            if (i < W) begin
                check("calc_no_valid", 32'(out_valid), 32'd0);
            end else begin
                check("latency_valid", 32'(out_valid), 32'd1);
                check("product", 32'(P), 32'(exp_p));
            end
        end
        for (int s = 0; s < stall; s++) begin
            A = W'($urandom); B = W'($urandom); in_valid = 1'($urandom);
            step();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_p", 32'(P), 32'(exp_p));
            check("stall_busy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        check("post_hs_valid", 32'(out_valid), 32'd0);
        check("post_hs_ready", 32'(in_ready), 32'd1);
        check("post_hs_p_hold", 32'(P), 32'(exp_p));
    endtask

    initial begin
        reset_L = 1'b0; in_valid = 1'b1; out_ready = 1'b1; A = 8'd13; B = 8'd11;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_p", 32'(P), 32'd0);
        reset_L = 1'b1; in_valid = 1'b0;
        step();
        check("rst_no_start", 32'(in_ready), 32'd1);

        do_op(8'd13, 8'd11, 0);
        do_op(8'd255, 8'd255, 0);
        do_op(8'd0, 8'd200, 0);
        do_op(8'd7, 8'd9, 5);
        do_op(8'd3, 8'd4, 0);

        // Abort an operation with reset on its third CALC edge.
        A = 8'd99; B = 8'd77; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        reset_L = 1'b0;
        step();
        reset_L = 1'b1;
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_p", 32'(P), 32'd0);
        for (int i = 0; i < W + 2; i++) begin
            step();
            check("abort_quiet", 32'(out_valid), 32'd0);
        end
        do_op(8'd5, 8'd6, 0);

        for (int n = 0; n < 12; n++) begin
            do_op(W'($urandom), W'($urandom), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
